// File: rtl/ebp_frame_reader_if.sv
// Bundle of request, memory-read and response signals for the EBP frame reader.
// The reader itself sits on the slave modport, and its driver sits on the master modport.
interface ebp_frame_reader_if #(
    parameter int ADDR_W = 32
);
    logic [ADDR_W-1:0] ebp;
    logic              req_valid;
    logic              req_ready;
    logic [7:0]        req_disp;
    logic              req_byte;
    logic              mem_rd;
    logic [ADDR_W-1:0] mem_addr;
    logic              mem_ack;
    logic [31:0]       mem_rdata;
    logic              rsp_valid;
    logic              rsp_ready;
    logic [31:0]       rsp_data;
    logic              rsp_err;

    modport slave (
        input  ebp,
        input  req_valid,
        output req_ready,
        input  req_disp,
        input  req_byte,
        output mem_rd,
        output mem_addr,
        input  mem_ack,
        input  mem_rdata,
        output rsp_valid,
        input  rsp_ready,
        output rsp_data,
        output rsp_err
    );

    modport master (
        output ebp,
        output req_valid,
        input  req_ready,
        output req_disp,
        output req_byte,
        input  mem_rd,
        input  mem_addr,
        output mem_ack,
        output mem_rdata,
        input  rsp_valid,
        output rsp_ready,
        input  rsp_data,
        input  rsp_err
    );
endinterface

// File: rtl/ebp_frame_reader.sv
// Resolves [ebp + disp8] operands: snapshots EBP on accept, runs a timed req/ack
// memory read, and returns the dword or zero-extended byte through valid/ready.
module ebp_frame_reader #(
    parameter int TIMEOUT = 16,
    parameter int ADDR_W  = 32
) (
    input  logic               clk,
    input  logic               reset,
    ebp_frame_reader_if.slave  bus
);
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        READ = 2'd1,
        RESP = 2'd2
    } state_t;

    localparam logic [7:0] CNT_LAST = 8'(TIMEOUT - 1);

    state_t            state_reg, state_next;
    logic [7:0]        cnt_reg, cnt_next;
    logic [1:0]        lane_reg, lane_next;
    logic              byte_reg, byte_next;
    logic              mem_rd_reg, mem_rd_next;
    logic [ADDR_W-1:0] mem_addr_reg, mem_addr_next;
    logic              rsp_valid_reg, rsp_valid_next;
    logic [31:0]       rsp_data_reg, rsp_data_next;
    logic              rsp_err_reg, rsp_err_next;

    logic [ADDR_W-1:0] ea;
    logic              misaligned;
    logic [7:0]        lanes [4];
    logic [31:0]       byte_data;

    // EBP is only consumed here, so it is effectively snapshotted on accept.
    assign ea         = bus.ebp + {{(ADDR_W-8){bus.req_disp[7]}}, bus.req_disp};
    assign misaligned = !bus.req_byte && (ea[1:0] != 2'b00);

    for (genvar gi = 0; gi < 4; gi++) begin : g_lane
        assign lanes[gi] = bus.mem_rdata[8*gi +: 8];
    end
    assign byte_data = {24'h0, lanes[lane_reg]};

    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg     <= IDLE;
            cnt_reg       <= 8'd0;
            lane_reg      <= 2'd0;
            byte_reg      <= 1'b0;
            mem_rd_reg    <= 1'b0;
            mem_addr_reg  <= '0;
            rsp_valid_reg <= 1'b0;
            rsp_data_reg  <= 32'd0;
            rsp_err_reg   <= 1'b0;
        end else begin
            state_reg     <= state_next;
            cnt_reg       <= cnt_next;
            lane_reg      <= lane_next;
            byte_reg      <= byte_next;
            mem_rd_reg    <= mem_rd_next;
            mem_addr_reg  <= mem_addr_next;
            rsp_valid_reg <= rsp_valid_next;
            rsp_data_reg  <= rsp_data_next;
            rsp_err_reg   <= rsp_err_next;
        end
    end

    always_comb begin
        state_next     = state_reg;
        cnt_next       = cnt_reg;
        lane_next      = lane_reg;
        byte_next      = byte_reg;
        mem_rd_next    = mem_rd_reg;
        mem_addr_next  = mem_addr_reg;
        rsp_valid_next = rsp_valid_reg;
        rsp_data_next  = rsp_data_reg;
        rsp_err_next   = rsp_err_reg;

        case (state_reg)
            IDLE: begin
                if (bus.req_valid) begin
                    if (misaligned) begin
                        rsp_valid_next = 1'b1;
                        rsp_err_next   = 1'b1;
                        rsp_data_next  = 32'd0;
                        state_next     = RESP;
                    end else begin
                        lane_next     = ea[1:0];
                        byte_next     = bus.req_byte;
                        mem_addr_next = {ea[ADDR_W-1:2], 2'b00};
                        cnt_next      = 8'd0;
                        mem_rd_next   = 1'b1;
                        state_next    = READ;
                    end
                end
            end
            READ: begin
                // Ack is tested before the limit so a coinciding ack still wins.
                if (bus.mem_ack) begin
                    mem_rd_next    = 1'b0;
                    rsp_valid_next = 1'b1;
                    rsp_err_next   = 1'b0;
                    rsp_data_next  = byte_reg ? byte_data : bus.mem_rdata;
                    state_next     = RESP;
                end else if (cnt_reg == CNT_LAST) begin
                    mem_rd_next    = 1'b0;
                    rsp_valid_next = 1'b1;
                    rsp_err_next   = 1'b1;
                    rsp_data_next  = 32'd0;
                    state_next     = RESP;
                end else begin
                    cnt_next = cnt_reg + 8'd1;
                end
            end
            RESP: begin
                if (bus.rsp_ready) begin
                    rsp_valid_next = 1'b0;
                    state_next     = IDLE;
                end
            end
            default: begin
                state_next     = IDLE;
                mem_rd_next    = 1'b0;
                rsp_valid_next = 1'b0;
            end
        endcase
    end

    assign bus.req_ready = (state_reg == IDLE);
    assign bus.mem_rd    = mem_rd_reg;
    assign bus.mem_addr  = mem_addr_reg;
    assign bus.rsp_valid = rsp_valid_reg;
    assign bus.rsp_data  = rsp_data_reg;
    assign bus.rsp_err   = rsp_err_reg;
endmodule

// File: tb/tb_ebp_frame_reader.sv
// Randomized bench for ebp_frame_reader; expected responses, strobe counts and
// latencies come from a transaction-level model of the operand read.
module tb_ebp_frame_reader;
    localparam int TIMEOUT = 16;

    logic clk = 1'b0;
    logic reset = 1'b1;
    int   n_cmp = 0;
    int   n_err = 0;
    int   n_txn = 0;

    ebp_frame_reader_if #(.ADDR_W(32)) bus ();

    ebp_frame_reader #(.TIMEOUT(TIMEOUT), .ADDR_W(32)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // wt = wait cycles before ack (ack in cycle wt+1 after accept); negative = never ack.
    task automatic run_txn(input logic [31:0] e, input logic [7:0] d, input logic b,
                           input int wt, input logic [31:0] rd, input int bp);
        logic [31:0] ea, exp_addr, exp_data, last_addr;
        logic        mis, tmo;
        int          exp_rd, exp_lat, rd_cnt, lat, guard;

        ea       = e + {{24{d[7]}}, d};
        mis      = !b && (ea[1:0] != 2'b00);
        tmo      = !mis && (wt < 0 || wt >= TIMEOUT);
        exp_addr = {ea[31:2], 2'b00};
        exp_rd   = mis ? 0 : (tmo ? TIMEOUT : wt + 1);
        exp_lat  = exp_rd + 1;
        if (mis || tmo)
            exp_data = 32'd0;
        else if (b)
            exp_data = (rd >> (8 * int'(ea[1:0]))) & 32'hFF;
        else
            exp_data = rd;

        guard = 0;
        while (!bus.req_ready && guard < 50) begin
            tick();
            guard++;
        end
        check_val("req_ready_idle", 32'(bus.req_ready), 32'd1);

        bus.ebp       = e;
        bus.req_disp  = d;
        bus.req_byte  = b;
        bus.req_valid = 1'b1;
        bus.mem_ack   = 1'($urandom_range(0, 1));
        bus.mem_rdata = $urandom;
        tick();
        bus.req_valid = 1'b0;
        bus.ebp       = $urandom;

        lat       = 1;
        rd_cnt    = 0;
        last_addr = 32'd0;
        while (!bus.rsp_valid && lat < 200) begin
            if (bus.mem_rd) begin
                rd_cnt++;
                last_addr = bus.mem_addr;
            end
            bus.mem_ack   = (lat == wt + 1);
            bus.mem_rdata = (lat == wt + 1) ? rd : $urandom;
            tick();
            lat++;
        end
        bus.mem_ack = 1'b0;

        check_val("rsp_latency", 32'(lat), 32'(exp_lat));
        check_val("mem_rd_cycles", 32'(rd_cnt), 32'(exp_rd));
        if (!mis)
            check_val("mem_addr", last_addr, exp_addr);
        check_val("rsp_data", bus.rsp_data, exp_data);
        check_val("rsp_err", 32'(bus.rsp_err), 32'(mis || tmo));
        check_val("mem_rd_resp", 32'(bus.mem_rd), 32'd0);
        check_val("req_ready_resp", 32'(bus.req_ready), 32'd0);

        for (int i = 0; i < bp; i++) begin
            tick();
            check_val("bp_valid", 32'(bus.rsp_valid), 32'd1);
            check_val("bp_data", bus.rsp_data, exp_data);
            check_val("bp_err", 32'(bus.rsp_err), 32'(mis || tmo));
            check_val("bp_req_ready", 32'(bus.req_ready), 32'd0);
        end

        bus.rsp_ready = 1'b1;
        tick();
        bus.rsp_ready = 1'b0;
        check_val("rsp_drop", 32'(bus.rsp_valid), 32'd0);
        check_val("req_ready_after", 32'(bus.req_ready), 32'd1);

        n_txn++;
        $display("txn %0d ebp=%08h disp=%02h byte=%0d wait=%0d bp=%0d -> addr=%08h data=%08h err=%0d lat=%0d",
                 n_txn, e, d, b, wt, bp, exp_addr, exp_data, mis || tmo, exp_lat);
    endtask

    task automatic reset_mid_read();
        int seen;
        bus.ebp       = 32'h0000_2000;
        bus.req_disp  = 8'h04;
        bus.req_byte  = 1'b0;
        bus.req_valid = 1'b1;
        tick();
        bus.req_valid = 1'b0;
        check_val("rst_rd_first", 32'(bus.mem_rd), 32'd1);
        tick();
        reset = 1'b1;
        tick();
        reset         = 1'b0;
        bus.mem_ack   = 1'b1;
        bus.mem_rdata = 32'hCAFE_F00D;
        check_val("rst_mem_rd", 32'(bus.mem_rd), 32'd0);
        check_val("rst_req_ready", 32'(bus.req_ready), 32'd1);
        check_val("rst_rsp_data", bus.rsp_data, 32'd0);
        tick();
        bus.mem_ack = 1'b0;
        seen = 0;
        for (int i = 0; i < 6; i++) begin
            if (bus.rsp_valid || bus.mem_rd) seen++;
            tick();
        end
        check_val("rst_no_rsp", 32'(seen), 32'd0);
        check_val("rst_idle_ready", 32'(bus.req_ready), 32'd1);
        $display("txn reset-mid-read: late ack ignored, activity cycles=%0d", seen);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] e, rd;
        logic [7:0]  d;
        logic        b;
        int          wt, r;

        bus.ebp       = 32'd0;
        bus.req_valid = 1'b0;
        bus.req_disp  = 8'd0;
        bus.req_byte  = 1'b0;
        bus.mem_ack   = 1'b0;
        bus.mem_rdata = 32'd0;
        bus.rsp_ready = 1'b0;

        reset = 1'b1;
        tick();
        tick();
        check_val("reset_req_ready", 32'(bus.req_ready), 32'd1);
        check_val("reset_mem_rd", 32'(bus.mem_rd), 32'd0);
        check_val("reset_mem_addr", bus.mem_addr, 32'd0);
        check_val("reset_rsp_valid", 32'(bus.rsp_valid), 32'd0);
        check_val("reset_rsp_data", bus.rsp_data, 32'd0);
        check_val("reset_rsp_err", 32'(bus.rsp_err), 32'd0);
        reset = 1'b0;
        tick();

        run_txn(32'h0000_1000, 8'h08, 1'b0, 0, 32'hDEAD_BEEF, 0);
        run_txn(32'h0000_1000, 8'hFD, 1'b1, 3, 32'h1122_3344, 0);
        run_txn(32'h0000_0999, 8'h00, 1'b0, 0, 32'h0, 2);
        run_txn(32'h0000_1000, 8'h10, 1'b0, -1, 32'h0, 5);
        run_txn(32'h0000_2000, 8'h00, 1'b0, TIMEOUT - 1, 32'hA5A5_5A5A, 1);
        run_txn(32'h0000_2000, 8'h00, 1'b0, TIMEOUT, 32'hA5A5_5A5A, 0);
        run_txn(32'h0000_0002, 8'hFC, 1'b1, 1, 32'h8877_6655, 0);
        run_txn(32'h0000_0003, 8'h00, 1'b1, 2, 32'hF1E2_D3C4, 0);

        reset_mid_read();
        run_txn(32'h0000_3000, 8'h7F, 1'b1, 0, 32'h0102_0304, 0);

        for (int n = 0; n < 40; n++) begin
            e = $urandom;
            if ($urandom_range(0, 3) != 0) e[1:0] = 2'b00;
            d  = 8'($urandom);
            b  = 1'($urandom_range(0, 1));
            rd = $urandom;
            r  = $urandom_range(0, 9);
            if (r < 6)       wt = r;
            else if (r == 6) wt = TIMEOUT - 2;
            else if (r == 7) wt = TIMEOUT - 1;
            else if (r == 8) wt = TIMEOUT;
            else             wt = -1;
            run_txn(e, d, b, wt, rd, $urandom_range(0, 3));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
